// File: rtl/seq_logic_unit_if.sv
// Request/result handshake bundle for the sequential bitwise logic unit.
// master: issue stage / result consumer; slave: the logic unit.
interface seq_logic_unit_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             ones;

   modport master (
      output in_valid, in1, in2, op, out_ready,
      input  in_ready, out_valid, out, zero, ones
   );

   modport slave (
      input  in_valid, in1, in2, op, out_ready,
      output in_ready, out_valid, out, zero, ones
   );
endinterface

// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates AND/OR/XOR/ANDN over WIDTH bits,
// SLICE bits per cycle, and hands the result back with zero/all-ones flags.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request (in_ready high)
// RUN   | writing one result slice per cycle, slice index = cnt
// DONE  | result and flags held, out_valid high until out_ready
module seq_logic_unit #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic               clk,
   input logic               rst_n,
   seq_logic_unit_if.slave   bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, out_q, res_nxt;
   logic [1:0]       op_q;
   logic [CW-1:0]    cnt;
   logic             zero_q, ones_q;
   logic [SLICE-1:0] sa, sb, slice_res;
   logic             accept, last;

   assign accept = (state == IDLE) && bus.in_valid;
   assign last   = (cnt == CW'(NSLICE - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = RUN;
         RUN:     if (last)         state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Current slice function and the full result as it will look after this slice
   always_comb begin
      sa = a_q[cnt*SLICE +: SLICE];
      sb = b_q[cnt*SLICE +: SLICE];
      case (op_q)
         2'b00:   slice_res = sa & sb;
         2'b01:   slice_res = sa | sb;
         2'b10:   slice_res = sa ^ sb;
         default: slice_res = sa & ~sb;
      endcase
      res_nxt = out_q;
      res_nxt[cnt*SLICE +: SLICE] = slice_res;
   end

   // Operand latch, slice counter, result and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         cnt    <= '0;
         out_q  <= '0;
         zero_q <= 1'b0;
         ones_q <= 1'b0;
      end else if (accept) begin
         a_q    <= bus.in1;
         b_q    <= bus.in2;
         op_q   <= bus.op;
         cnt    <= '0;
         out_q  <= '0;
         zero_q <= 1'b0;
         ones_q <= 1'b0;
      end else if (state == RUN) begin
         out_q <= res_nxt;
         if (last) begin
            // Hold the counter on the final slice so it never indexes past the word
            zero_q <= (res_nxt == '0);
            ones_q <= &res_nxt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out       = out_q;
   assign bus.zero      = zero_q;
   assign bus.ones      = ones_q;
endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed bench for seq_logic_unit: three parameterisations, checked at the
// falling edge with immediate assertions against hand-computed results.
module tb_seq_logic_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   seq_logic_unit_if #(.WIDTH(16)) b16 ();
   seq_logic_unit_if #(.WIDTH(32)) b32 ();
   seq_logic_unit_if #(.WIDTH(8))  b8 ();

   seq_logic_unit #(.WIDTH(16), .SLICE(4))  u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   seq_logic_unit #(.WIDTH(32), .SLICE(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   seq_logic_unit #(.WIDTH(8),  .SLICE(1))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request on the 16-bit unit from a falling edge in IDLE; returns
   // cycles from the accept edge to out_valid (-1 if it never came).
   task automatic run16(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] o, output int lat);
      b16.in1 = a; b16.in2 = b; b16.op = o; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            b16.in_valid = 1'b0;
            b16.in1 = 16'($urandom);
            b16.in2 = 16'($urandom);
         end
         if (b16.out_valid) begin
            lat = c - 1;
            break;
         end
      end
   endtask

   task automatic release16(input string tag);
      b16.out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_rel_in_ready"}, 32'(b16.in_ready), 32'd1);
      chk({tag, "_rel_out_valid"}, 32'(b16.out_valid), 32'd0);
      b16.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic [15:0] exp_all [4];
      logic [15:0] held;

      b16.in_valid = 0; b16.in1 = 0; b16.in2 = 0; b16.op = 0; b16.out_ready = 0;
      b32.in_valid = 0; b32.in1 = 0; b32.in2 = 0; b32.op = 0; b32.out_ready = 0;
      b8.in_valid  = 0; b8.in1  = 0; b8.in2  = 0; b8.op  = 0; b8.out_ready  = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(b16.in_ready), 32'd1);
      chk("rst_out_valid", 32'(b16.out_valid), 32'd0);
      chk("rst_out", 32'(b16.out), 32'h0);
      chk("rst_zero", 32'(b16.zero), 32'd0);
      chk("rst_ones", 32'(b16.ones), 32'd0);
      rst_n = 1'b1;

      // Basic OR
      run16(16'h00F0, 16'h0F00, 2'b01, lat);
      chk("or_lat", 32'(lat), 32'd4);
      chk("or_out", 32'(b16.out), 32'h0FF0);
      chk("or_zero", 32'(b16.zero), 32'd0);
      chk("or_ones", 32'(b16.ones), 32'd0);
      chk("or_in_ready", 32'(b16.in_ready), 32'd0);
      release16("or");

      // All four functions with operands scrambled after accept
      exp_all[0] = 16'hA500; exp_all[1] = 16'hFFA5; exp_all[2] = 16'h5AA5; exp_all[3] = 16'h00A5;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         run16(16'hA5A5, 16'hFF00, 2'(k), lat);
         chk($sformatf("op%0d_lat", k), 32'(lat), 32'd4);
         chk($sformatf("op%0d_out", k), 32'(b16.out), 32'(exp_all[k]));
         release16($sformatf("op%0d", k));
      end

      // Flags
      run16(16'hFFFF, 16'h0000, 2'b00, lat);
      chk("zf_out", 32'(b16.out), 32'h0);
      chk("zf_zero", 32'(b16.zero), 32'd1);
      chk("zf_ones", 32'(b16.ones), 32'd0);
      release16("zf");
      run16(16'hFF00, 16'h00FF, 2'b01, lat);
      chk("of_out", 32'(b16.out), 32'hFFFF);
      chk("of_zero", 32'(b16.zero), 32'd0);
      chk("of_ones", 32'(b16.ones), 32'd1);

      // Backpressure: hold the result for 10 cycles while pulsing in_valid
      for (int c = 0; c < 10; c++) begin
         b16.in_valid = c[0];
         b16.in1 = 16'h1234; b16.in2 = 16'h4321; b16.op = 2'b10;
         @(negedge clk);
         chk("bp_out_valid", 32'(b16.out_valid), 32'd1);
         chk("bp_in_ready", 32'(b16.in_ready), 32'd0);
         chk("bp_out", 32'(b16.out), 32'hFFFF);
         chk("bp_ones", 32'(b16.ones), 32'd1);
      end
      b16.in_valid = 1'b0;
      release16("bp");
      @(negedge clk);
      chk("bp_not_queued", 32'(b16.in_ready), 32'd1);

      // Reset in the second RUN cycle (after slice 0 has been written)
      b16.in1 = 16'h000F; b16.in2 = 16'h0000; b16.op = 2'b01; b16.in_valid = 1'b1;
      @(negedge clk);
      b16.in_valid = 1'b0;
      @(negedge clk);
      held = b16.out;
      chk("mid_slice0", 32'(held), 32'h000F);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 32'(b16.out), 32'h0);
      chk("mid_rst_out_valid", 32'(b16.out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(b16.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run16(16'h0F0F, 16'h00FF, 2'b10, lat);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_out", 32'(b16.out), 32'h0FF0);
      release16("post_rst");

      // Single-cycle configuration
      b32.in1 = 32'hFFFF0000; b32.in2 = 32'h0F0F0F0F; b32.op = 2'b10; b32.in_valid = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         b32.in_valid = 1'b0;
         if (b32.out_valid) begin lat = c - 1; break; end
      end
      chk("w32_lat", 32'(lat), 32'd1);
      chk("w32_out", b32.out, 32'hF0F00F0F);
      b32.out_ready = 1'b1;
      @(negedge clk);
      chk("w32_rel", 32'(b32.in_ready), 32'd1);
      b32.out_ready = 1'b0;

      // Bit-serial configuration
      b8.in1 = 8'h81; b8.in2 = 8'h18; b8.op = 2'b01; b8.in_valid = 1'b1;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         if (b8.out_valid) begin lat = c - 1; break; end
      end
      chk("w8_lat", 32'(lat), 32'd8);
      chk("w8_out", 32'(b8.out), 32'h99);
      chk("w8_zero", 32'(b8.zero), 32'd0);
      b8.out_ready = 1'b1;
      @(negedge clk);
      chk("w8_rel", 32'(b8.in_ready), 32'd1);
      b8.out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/seq_logic_unit.md
# seq_logic_unit

Parametrised, multi-cycle bitwise logic unit for the ALU datapath, succeeding the fixed 16-bit single-function gate-level OR. It accepts two WIDTH-bit operands and an operation code, evaluates the bitwise function SLICE bits per cycle, and returns the result through a valid/ready handshake. It also returns zero and all-ones flags for the branch and flag logic. It sits between the decode/issue stage and the ALU result mux.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits evaluated per cycle; NSLICE = WIDTH/SLICE; SLICE == WIDTH gives single-cycle evaluation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  unit can accept a request; high exactly in IDLE.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- op  in  2  function select: 00 AND, 01 OR, 10 XOR, 11 ANDN (in1 & ~in2).
- out_valid  out  1  result valid; high exactly in DONE.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result register.
- zero  out  1  out == 0; meaningful only while out_valid is high.
- ones  out  1  out is all ones; meaningful only while out_valid is high.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid & in_ready.
  - RUN -> DONE when the slice counter reaches NSLICE-1.
  - DONE -> IDLE on out_ready.
- Accept (IDLE, in_valid high):
  - in1, in2 and op are latched into internal registers.
  - The slice counter is cleared to 0.
  - out is cleared to 0.
  - Operand inputs are don't-care after the accept cycle.
- RUN:
  - Each cycle, out[k*SLICE +: SLICE] = f(opA slice k, opB slice k), where k is the counter value.
  - The counter then increments. Slices are written in order 0 .. NSLICE-1.
  - Bits not yet written read 0.
- DONE:
  - out, zero and ones hold stable until out_ready is sampled high.
  - New requests are not accepted; in_ready is low.
- Flags: zero and ones are registered.
  - Both are computed from the final full-width result on the RUN -> DONE transition.
  - Both are cleared on accept.
- Counter width: clog2(NSLICE), minimum 1 bit. The counter never wraps in normal operation; it is reset on every accept.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after the DONE -> IDLE transition.
- Reset (rst_n low, at any time, including mid-RUN or in DONE):
  - state goes to IDLE; counter, out, zero, ones and the latched operands go to 0.
  - out_valid goes to 0 and in_ready to 1.
  - Any in-flight request is discarded with no result produced.
- Release of rst_n is assumed synchronised externally. The first accept may occur on the first rising edge after release.

## Timing
- Accept edge T0: state becomes RUN.
- Edges T1 .. T_NSLICE each write one slice. At edge T_NSLICE, state becomes DONE and out_valid is high from then on.
- Latency from the accept edge to out_valid high is NSLICE cycles. With SLICE == WIDTH, latency is 1 cycle.
- Minimum issue interval is NSLICE + 2 cycles: accept, NSLICE run cycles, one IDLE cycle.
- out_ready high in the first DONE cycle releases the result after exactly one cycle of out_valid.
- Holding out_ready low stalls indefinitely with the result held.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- out_ready sampled while not in DONE has no effect. in_valid sampled while not in IDLE has no effect and is not queued.

## Test plan
- OR, WIDTH=16, SLICE=4: in1=16'h00F0, in2=16'h0F00, op=01 -> out_valid high 4 cycles after accept, out=16'h0FF0, zero=0, ones=0.
- All ops on in1=16'hA5A5, in2=16'hFF00:
  - AND -> 16'hA500; OR -> 16'hFFA5; XOR -> 16'h5AA5; ANDN -> 16'h00A5.
  - For each op, in1/in2 are changed to random values on the cycle after accept; the result must not change.
- Flags: AND of 16'hFFFF and 16'h0000 -> out=0, zero=1; OR of 16'hFF00 and 16'h00FF -> out=16'hFFFF, ones=1.
- Backpressure: out_ready held low for 10 cycles in DONE -> out, out_valid and flags stable, in_ready low; in_valid pulses during this time are ignored. out_ready then raised -> IDLE next cycle.
- Reset mid-operation: rst_n pulled low in the 2nd RUN cycle -> immediately out=0, out_valid=0, in_ready=1. A new request after release completes normally in 4 cycles.
- Parameter sweep:
  - WIDTH=32, SLICE=32: XOR of 32'hFFFF0000 and 32'h0F0F0F0F -> 32'hF0F00F0F after 1 cycle.
  - WIDTH=8, SLICE=1: OR of 8'h81 and 8'h18 -> 8'h99 after 8 cycles.
